// File: rtl/block_bank_ctrl_pkg.sv
// ============================================================================
//  block_bank_ctrl_pkg : FSM state and block-operation encodings
//  Revision 1.0
// ============================================================================
`default_nettype none

package block_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2
  } op_t;

  // Clear outranks write when a requester raises both.
  function automatic op_t decode_op(input logic wr, input logic clr);
    return clr ? OP_CLEAR : (wr ? OP_WRITE : OP_READ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_bank_ctrl_arb.sv
// ============================================================================
//  rr_arbiter : combinational round-robin pick, searching upward from i_ptr
//  Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import block_bank_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_gnt_id
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found       = 1'b1;
        o_gnt_id      = w_idx;
        o_gnt[w_idx]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_bank_ctrl.sv
// ============================================================================
//  block_bank_ctrl : shares a bank of storage blocks among NREQ requesters,
//  one transaction in flight, with ack timeout.   Revision 1.0
// ============================================================================
`default_nettype none

module block_bank_ctrl
  import block_bank_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   i_req,
  input  logic [NREQ-1:0]                   i_req_write,
  input  logic [NREQ-1:0]                   i_req_clear,
  input  logic [NREQ*ADDR_W-1:0]            i_req_addr,
  input  logic [NREQ*DATA_W-1:0]            i_req_wdata,
  output logic [NREQ-1:0]                   o_done,
  output logic                              o_err,
  output logic [DATA_W-1:0]                 o_rdata,
  output logic [(1<<ADDR_W)-1:0]            o_blk_enable,
  output logic                              o_blk_write,
  output logic                              o_blk_rst,
  output logic [DATA_W-1:0]                 o_blk_wdata,
  input  logic [(1<<ADDR_W)*DATA_W-1:0]     i_blk_rdata,
  input  logic [(1<<ADDR_W)-1:0]            i_blk_ack
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMO_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  op_t                 r_op;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [TMO_W-1:0]    r_tmo;

  logic [NREQ-1:0]     w_gnt;
  logic [ID_W-1:0]     w_gnt_id;
  logic                w_any;
  logic                w_ack_sel;
  logic                w_tmo_hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign w_any     = |w_gnt;
  assign w_ack_sel = i_blk_ack[r_addr];
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request fields are captured once at grant; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_addr  <= '0;
      r_op    <= OP_READ;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_gnt_id;
            r_addr  <= i_req_addr[w_gnt_id*ADDR_W +: ADDR_W];
            r_wdata <= i_req_wdata[w_gnt_id*DATA_W +: DATA_W];
            r_op    <= decode_op(i_req_write[w_gnt_id], i_req_clear[w_gnt_id]);
          end
        end
        S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_ack_sel) begin
            r_rdata <= i_blk_rdata[r_addr*DATA_W +: DATA_W];
            r_err   <= 1'b0;
          end else if (w_tmo_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end
        end
        S_RESP: begin
          r_ptr <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
          r_tmo <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_blk_enable = '0;
    o_blk_write  = 1'b0;
    o_blk_rst    = 1'b0;
    o_blk_wdata  = '0;
    o_done       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE, S_WAIT: begin
        o_blk_enable[r_addr] = 1'b1;
        o_blk_write          = (r_op == OP_WRITE);
        o_blk_rst            = (r_op == OP_CLEAR);
        o_blk_wdata          = r_wdata;
        if (r_state == S_ISSUE)        w_state_nxt = S_WAIT;
        else if (w_ack_sel || w_tmo_hit) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_done[r_id] = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_err   = r_err && (r_state == S_RESP);
  assign o_rdata = r_rdata;

endmodule

`default_nettype wire
